hazard_scoreboard: RTL and testbench

Parametrised hazard and forwarding controller for the 5-stage pipeline. It tracks in-flight destination registers in EX, MEM and WB in a small shift-register scoreboard. From that it generates registered EX forwarding selects, ID-stage branch/JR operand forwarding, load-use and ID-use stalls, and multi-cycle-memory freeze. A halt-drain FSM reports when the pipeline is empty after HALT. It replaces the flag-per-hazard scheme with one table-driven unit sized by register count.

---
 rtl/hazard_pkg.sv | 53 +++++
 rtl/sb_match.sv | 24 ++
 rtl/hazard_scoreboard.sv | 165 ++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings and types for the hazard/forwarding scoreboard.
// Optional statistics in hazard_scoreboard are enabled with the HAZ_STATS_EN macro.
package hazard_pkg;

    // Widest register address an entry can hold. Smaller register files
    // zero-extend their addresses into this field (supports NREG up to 256).
    localparam int RA_MAX_W = 8;

    // EX operand source selects
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // Scoreboard slot indices, youngest first
    localparam int SB_E     = 0;
    localparam int SB_M     = 1;
    localparam int SB_W     = 2;
    localparam int SB_DEPTH = 3;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } hz_state_t;

    // One in-flight instruction
    typedef struct packed {
        logic                v;
        logic                wr;
        logic [RA_MAX_W-1:0] addr;
        logic                ld;
    } sb_entry_t;

    // Match results of one entry against the two ID source operands
    typedef struct packed {
        logic rs;
        logic rt;
        logic ld_rs;
        logic ld_rt;
    } sb_hit_t;

    // Youngest producer wins. A WB-stage producer needs no bypass because the
    // register file writes through, so it resolves to the register file.
    function automatic logic [1:0] fwd_select(input logic e_alu_hit,
                                              input logic m_hit,
                                              input logic w_hit);
        if (e_alu_hit)  return FWD_EXMEM;
        else if (m_hit) return FWD_MEMWB;
        else if (w_hit) return FWD_RF;
        else            return FWD_RF;
    endfunction

endpackage

// File: rtl/sb_match.sv
// sb_match: compares one scoreboard entry against both ID source operands.
module sb_match
    import hazard_pkg::*;
(
    input  sb_entry_t           ent,
    input  logic [RA_MAX_W-1:0] rs,
    input  logic                rs_used,
    input  logic [RA_MAX_W-1:0] rt,
    input  logic                rt_used,
    output sb_hit_t             hit
);

    logic live;

    // An entry can only satisfy a read if it is valid and writes a register.
    always_comb begin
        live      = ent.v & ent.wr;
        hit.rs    = live & (ent.addr == rs) & rs_used;
        hit.rt    = live & (ent.addr == rt) & rt_used;
        hit.ld_rs = live & (ent.addr == rs) & rs_used & ent.ld;
        hit.ld_rt = live & (ent.addr == rt) & rt_used & ent.ld;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: table-driven hazard and forwarding control for the 5-stage
// pipeline. Tracks EX/MEM/WB destinations, produces stalls, bubbles, forwarding
// selects and a halt-drain indication.
// Build option: define HAZ_STATS_EN to build the saturating load-use and
// memory-stall counters; otherwise stat_lu / stat_mem are tied to 0.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter  int NREG  = 8,
    parameter  int CNT_W = 16,
    localparam int RA_W  = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             id_use_in_id,
    input  logic             id_wr_en,
    input  logic [RA_W-1:0]  id_wr_addr,
    input  logic             id_is_load,
    input  logic             id_is_halt,
    input  logic             flush,
    input  logic             mem_stall,
    output logic             stall,
    output logic             bubble,
    output logic [1:0]       ex_fwd_rs,
    output logic [1:0]       ex_fwd_rt,
    output logic             id_fwd_rs,
    output logic             id_fwd_rt,
    output logic             halt_done,
    output logic [CNT_W-1:0] stat_lu,
    output logic [CNT_W-1:0] stat_mem
);

    sb_entry_t           sb_reg  [SB_DEPTH];
    sb_entry_t           sb_next [SB_DEPTH];
    sb_hit_t             hit     [SB_DEPTH];
    logic [1:0]          ex_fwd_rs_reg, ex_fwd_rs_next;
    logic [1:0]          ex_fwd_rt_reg, ex_fwd_rt_next;
    hz_state_t           state_reg, state_next;
    logic [RA_MAX_W-1:0] rs_ext, rt_ext, wr_ext;
    logic                load_use, id_use, not_run, stall_raw, bubble_raw, issue;

    assign rs_ext = RA_MAX_W'(id_rs);
    assign rt_ext = RA_MAX_W'(id_rt);
    assign wr_ext = RA_MAX_W'(id_wr_addr);

    // One comparator per scoreboard slot (E, M, W)
    generate
        for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_match
            sb_match u_match (
                .ent     (sb_reg[gi]),
                .rs      (rs_ext),
                .rs_used (id_rs_used),
                .rt      (rt_ext),
                .rt_used (id_rt_used),
                .hit     (hit[gi])
            );
        end
    endgenerate

    // Hazard detection, stall/bubble generation and ID-stage bypass.
    always_comb begin
        load_use   = id_valid & (hit[SB_E].ld_rs | hit[SB_E].ld_rt);
        id_use     = id_valid & id_use_in_id &
                     (hit[SB_E].rs | hit[SB_E].rt | hit[SB_M].ld_rs | hit[SB_M].ld_rt);
        stall_raw  = mem_stall | (~flush & (load_use | id_use)) | not_run;
        bubble_raw = ~mem_stall & (flush | load_use | id_use | not_run);
        issue      = id_valid & ~stall_raw & ~flush;
    end

    // Outputs are held low while reset is asserted, whatever the inputs do.
    assign stall     = rst & stall_raw;
    assign bubble    = rst & bubble_raw;
    assign id_fwd_rs = rst & id_valid & id_use_in_id & hit[SB_M].rs & ~hit[SB_M].ld_rs;
    assign id_fwd_rt = rst & id_valid & id_use_in_id & hit[SB_M].rt & ~hit[SB_M].ld_rt;
    assign ex_fwd_rs = ex_fwd_rs_reg;
    assign ex_fwd_rt = ex_fwd_rt_reg;

    // Shift the scoreboard and compute next EX forwarding selects.
    always_comb begin
        for (int i = 0; i < SB_DEPTH; i++) sb_next[i] = sb_reg[i];
        ex_fwd_rs_next = ex_fwd_rs_reg;
        ex_fwd_rt_next = ex_fwd_rt_reg;
        if (!mem_stall) begin
            sb_next[SB_W]  = sb_reg[SB_M];
            sb_next[SB_M]  = sb_reg[SB_E];
            sb_next[SB_E]  = '0;
            ex_fwd_rs_next = FWD_RF;
            ex_fwd_rt_next = FWD_RF;
            if (issue) begin
                sb_next[SB_E]  = '{v: 1'b1, wr: id_wr_en, addr: wr_ext, ld: id_is_load};
                ex_fwd_rs_next = fwd_select(hit[SB_E].rs & ~hit[SB_E].ld_rs,
                                            hit[SB_M].rs, hit[SB_W].rs);
                ex_fwd_rt_next = fwd_select(hit[SB_E].rt & ~hit[SB_E].ld_rt,
                                            hit[SB_M].rt, hit[SB_W].rt);
            end
        end
    end

    // Scoreboard and forwarding-select registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SB_DEPTH; i++) sb_reg[i] <= '0;
            ex_fwd_rs_reg <= FWD_RF;
            ex_fwd_rt_reg <= FWD_RF;
        end else begin
            for (int i = 0; i < SB_DEPTH; i++) sb_reg[i] <= sb_next[i];
            ex_fwd_rs_reg <= ex_fwd_rs_next;
            ex_fwd_rt_reg <= ex_fwd_rt_next;
        end
    end

    // Halt FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= RUN;
        else      state_reg <= state_next;
    end

    // Halt FSM next state. Emptiness is judged on the values being loaded so
    // DONE is entered on the same edge the HALT leaves WB.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            RUN:     if (issue && id_is_halt) state_next = DRAIN;
            DRAIN:   if (!(sb_next[SB_E].v || sb_next[SB_M].v || sb_next[SB_W].v))
                         state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = RUN;
        endcase
    end

    // Halt FSM outputs.
    always_comb begin
        not_run   = (state_reg != RUN);
        halt_done = (state_reg == DONE);
    end

`ifdef HAZ_STATS_EN
    logic [CNT_W-1:0] stat_lu_reg, stat_mem_reg;

    // Saturating load-use and memory-stall counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_lu_reg  <= '0;
            stat_mem_reg <= '0;
        end else begin
            if (load_use && !flush && !(&stat_lu_reg))
                stat_lu_reg <= stat_lu_reg + CNT_W'(1);
            if (mem_stall && !(&stat_mem_reg))
                stat_mem_reg <= stat_mem_reg + CNT_W'(1);
        end
    end

    assign stat_lu  = stat_lu_reg;
    assign stat_mem = stat_mem_reg;
`else
    assign stat_lu  = '0;
    assign stat_mem = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: scripted pipeline scenarios; expected outputs are queued
// when each ID instruction is driven and compared as the DUT responds.
module tb_hazard_scoreboard;

    localparam int NREG  = 8;
    localparam int CNT_W = 16;
`ifdef HAZ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid, id_rs_used, id_rt_used, id_use_in_id;
    logic [2:0]       id_rs, id_rt, id_wr_addr;
    logic             id_wr_en, id_is_load, id_is_halt, flush, mem_stall;
    logic             stall, bubble, id_fwd_rs, id_fwd_rt, halt_done;
    logic [1:0]       ex_fwd_rs, ex_fwd_rt;
    logic [CNT_W-1:0] stat_lu, stat_mem;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NREG(NREG), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rs_used   (id_rs_used),
        .id_rt_used   (id_rt_used),
        .id_use_in_id (id_use_in_id),
        .id_wr_en     (id_wr_en),
        .id_wr_addr   (id_wr_addr),
        .id_is_load   (id_is_load),
        .id_is_halt   (id_is_halt),
        .flush        (flush),
        .mem_stall    (mem_stall),
        .stall        (stall),
        .bubble       (bubble),
        .ex_fwd_rs    (ex_fwd_rs),
        .ex_fwd_rt    (ex_fwd_rt),
        .id_fwd_rs    (id_fwd_rs),
        .id_fwd_rt    (id_fwd_rt),
        .halt_done    (halt_done),
        .stat_lu      (stat_lu),
        .stat_mem     (stat_mem)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    typedef struct {
        logic       st, bu, fs, ft;
        logic [1:0] xs, xt;
        logic       dn;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    // One ID cycle: queue expectations, check combinational outputs mid-cycle,
    // then check registered outputs just after the clock edge.
    task automatic cyc(input string tag, input logic st, bu, fs, ft,
                       input logic [1:0] xs, xt, input logic dn);
        exp_t  e;
        exp_t  h;
        string t;
        e.st = st; e.bu = bu; e.fs = fs; e.ft = ft; e.xs = xs; e.xt = xt; e.dn = dn;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #2;
        h = exp_q[0];
        t = tag_q[0];
        check({t, ".stall"},     32'(stall),     32'(h.st));
        check({t, ".bubble"},    32'(bubble),    32'(h.bu));
        check({t, ".id_fwd_rs"}, 32'(id_fwd_rs), 32'(h.fs));
        check({t, ".id_fwd_rt"}, 32'(id_fwd_rt), 32'(h.ft));
        @(posedge clk);
        #1;
        h = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, ".ex_fwd_rs"}, 32'(ex_fwd_rs), 32'(h.xs));
        check({t, ".ex_fwd_rt"}, 32'(ex_fwd_rt), 32'(h.xt));
        check({t, ".halt_done"}, 32'(halt_done), 32'(h.dn));
        $display("%-10s stall=%b bubble=%b id_fwd=%b%b ex_fwd=%b/%b halt_done=%b",
                 t, stall, bubble, id_fwd_rs, id_fwd_rt, ex_fwd_rs, ex_fwd_rt, halt_done);
        @(negedge clk);
    endtask

    task automatic ins(input int rs, input bit rsu, input int rt, input bit rtu,
                       input bit uid, input bit wr, input int wa, input bit ld, input bit hlt);
        id_valid = 1'b1;   id_rs = 3'(rs);     id_rs_used = rsu;
        id_rt = 3'(rt);    id_rt_used = rtu;   id_use_in_id = uid;
        id_wr_en = wr;     id_wr_addr = 3'(wa);
        id_is_load = ld;   id_is_halt = hlt;
        flush = 1'b0;      mem_stall = 1'b0;
    endtask

    task automatic op_idle();
        ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
        id_valid = 1'b0;
    endtask
    task automatic op_alu(input int wa, input int rs, input int rt);
        ins(rs, 1, rt, 1, 0, 1, wa, 0, 0);
    endtask
    task automatic op_ld(input int wa, input int base);
        ins(base, 1, 0, 0, 0, 1, wa, 1, 0);
    endtask
    task automatic op_beqz(input int rs);
        ins(rs, 1, 0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic drain();
        repeat (3) begin
            op_idle();
            cyc("drain", 0, 0, 0, 0, 2'b00, 2'b00, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset with hostile inputs: every output must still read 0
        rst = 1'b0;
        op_alu(1, 1, 1);
        flush = 1'b1;
        mem_stall = 1'b1;
        #12;
        check("rst.stall",     32'(stall),     0);
        check("rst.bubble",    32'(bubble),    0);
        check("rst.id_fwd_rs", 32'(id_fwd_rs), 0);
        check("rst.id_fwd_rt", 32'(id_fwd_rt), 0);
        check("rst.ex_fwd_rs", 32'(ex_fwd_rs), 0);
        check("rst.ex_fwd_rt", 32'(ex_fwd_rt), 0);
        check("rst.halt_done", 32'(halt_done), 0);
        check("rst.stat_lu",   32'(stat_lu),   0);
        check("rst.stat_mem",  32'(stat_mem),  0);
        op_idle();
        @(negedge clk);
        rst = 1'b1;

        // ALU -> ALU forwarding: distance 1, distance 2, WB only, youngest wins
        op_alu(3, 1, 2);                   cyc("a_add3",  0, 0, 0, 0, 2'b00, 2'b00, 0);
        op_alu(6, 3, 5);                   cyc("a_use3",  0, 0, 0, 0, 2'b01, 2'b00, 0);
        op_alu(1, 0, 0);                   cyc("a_add1",  0, 0, 0, 0, 2'b00, 2'b00, 0);
        op_alu(2, 7, 6);                   cyc("a_gap6",  0, 0, 0, 0, 2'b00, 2'b10, 0);
        op_alu(2, 6, 2);                   cyc("a_wb6",   0, 0, 0, 0, 2'b00, 2'b01, 0);
        ins(0, 0, 0, 0, 0, 1, 2, 0, 0);    cyc("a_wr2",   0, 0, 0, 0, 2'b00, 2'b00, 0);
        ins(2, 1, 2, 1, 0, 0, 0, 0, 0);    cyc("a_young", 0, 0, 0, 0, 2'b01, 2'b01, 0);
        drain();

        // Load-use: one stall/bubble cycle, then MEM/WB forward
        op_ld(2, 1);                       cyc("b_ld2",   0, 0, 0, 0, 2'b00, 2'b00, 0);
        op_alu(4, 3, 2);                   cyc("b_lu",    1, 1, 0, 0, 2'b00, 2'b00, 0);
        op_alu(4, 3, 2);                   cyc("b_go",    0, 0, 0, 0, 2'b00, 2'b10, 0);
        check("b.stat_lu", 32'(stat_lu), STATS ? 1 : 0);
        drain();

        // Branch operand needed in ID after an ALU op: one stall, then ID bypass
        op_alu(4, 1, 1);                   cyc("c_add4",  0, 0, 0, 0, 2'b00, 2'b00, 0);
        op_beqz(4);                        cyc("c_stall", 1, 1, 0, 0, 2'b00, 2'b00, 0);
        op_beqz(4);                        cyc("c_fwd",   0, 0, 1, 0, 2'b10, 2'b00, 0);
        drain();

        // Branch after a load: two stall cycles
        op_ld(4, 1);                       cyc("d_ld4",   0, 0, 0, 0, 2'b00, 2'b00, 0);
        op_beqz(4);                        cyc("d_st1",   1, 1, 0, 0, 2'b00, 2'b00, 0);
        op_beqz(4);                        cyc("d_st2",   1, 1, 0, 0, 2'b00, 2'b00, 0);
        op_beqz(4);                        cyc("d_go",    0, 0, 0, 0, 2'b00, 2'b00, 0);
        check("d.stat_lu", 32'(stat_lu), STATS ? 2 : 0);
        drain();

        // Load-use coinciding with flush: flush wins, squashed op never enters EX
        op_ld(5, 1);                       cyc("e_ld5",   0, 0, 0, 0, 2'b00, 2'b00, 0);
        op_alu(6, 5, 0); flush = 1'b1;     cyc("e_flush", 0, 1, 0, 0, 2'b00, 2'b00, 0);
        op_alu(7, 6, 6);                   cyc("e_after", 0, 0, 0, 0, 2'b00, 2'b00, 0);
        check("e.stat_lu", 32'(stat_lu), STATS ? 2 : 0);
        drain();

        // Memory freeze for three cycles mid-forward
        op_alu(3, 1, 1);                   cyc("f_add3",  0, 0, 0, 0, 2'b00, 2'b00, 0);
        op_alu(6, 3, 0);                   cyc("f_add6",  0, 0, 0, 0, 2'b01, 2'b00, 0);
        for (int i = 0; i < 3; i++) begin
            op_alu(1, 3, 6); mem_stall = 1'b1;
            cyc("f_frz",   1, 0, 0, 0, 2'b01, 2'b00, 0);
        end
        op_alu(1, 3, 6);                   cyc("f_resume", 0, 0, 0, 0, 2'b10, 2'b01, 0);
        check("f.stat_mem", 32'(stat_mem), STATS ? 3 : 0);
        drain();

        // HALT with two older instructions: halt_done three cycles after HALT enters EX
        op_alu(1, 0, 0);                   cyc("h_add1",  0, 0, 0, 0, 2'b00, 2'b00, 0);
        op_alu(2, 0, 0);                   cyc("h_add2",  0, 0, 0, 0, 2'b00, 2'b00, 0);
        ins(0, 0, 0, 0, 0, 0, 0, 0, 1);    cyc("h_halt",  0, 0, 0, 0, 2'b00, 2'b00, 0);
        op_idle();                         cyc("h_dr1",   1, 1, 0, 0, 2'b00, 2'b00, 0);
        op_idle();                         cyc("h_dr2",   1, 1, 0, 0, 2'b00, 2'b00, 0);
        op_idle();                         cyc("h_dr3",   1, 1, 0, 0, 2'b00, 2'b00, 1);
        op_idle();                         cyc("h_done",  1, 1, 0, 0, 2'b00, 2'b00, 1);
        #3 rst = 1'b0;
        #1;
        check("h.rst_halt_done", 32'(halt_done), 0);
        check("h.rst_bubble",    32'(bubble),    0);
        @(negedge clk);
        rst = 1'b1;

        // Asynchronous reset just after HALT enters EX (FSM in DRAIN)
        op_alu(1, 0, 0);                   cyc("g_add1",  0, 0, 0, 0, 2'b00, 2'b00, 0);
        ins(1, 1, 0, 0, 0, 0, 0, 0, 1);    cyc("g_halt",  0, 0, 0, 0, 2'b01, 2'b00, 0);
        op_idle();
        #2;
        check("g.drain_stall", 32'(stall), 1);
        #1 rst = 1'b0;
        #1;
        check("g.rst_stall",     32'(stall),     0);
        check("g.rst_bubble",    32'(bubble),    0);
        check("g.rst_halt_done", 32'(halt_done), 0);
        check("g.rst_ex_fwd_rs", 32'(ex_fwd_rs), 0);
        check("g.rst_stat_lu",   32'(stat_lu),   0);
        check("g.rst_stat_mem",  32'(stat_mem),  0);
        @(negedge clk);
        rst = 1'b1;

        // Back in RUN with a clean scoreboard
        op_alu(3, 1, 1);                   cyc("p_add3",  0, 0, 0, 0, 2'b00, 2'b00, 0);
        op_alu(5, 3, 3);                   cyc("p_use3",  0, 0, 0, 0, 2'b01, 2'b01, 0);
        drain();

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
